borus_cpu_core_v2: RTL and testbench

Second-generation Borus CPU core: a single-issue, one-instruction-per-clock processor with a parametrised data width, a 4-entry register file, Z/C flags, conditional jumps, a hardware call/return stack and an input port. Instruction memory is external and combinational: the core drives `instr_addr` and consumes `instr_data` in the same cycle. The core sits between the program ROM and the board I/O, as a drop-in successor to the first-generation accumulator core.

---
 rtl/borus_cpu_pkg.sv | 42 ++++
 rtl/borus_alu.sv | 32 +++
 rtl/borus_cpu_core_v2.sv | 170 +++++++++++++++++
 tb/tb_borus_cpu_core_v2.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/borus_cpu_pkg.sv
// Shared definitions for the Borus v2 core: opcodes, core states and
// instruction field layout.
package borus_cpu_pkg;

    localparam int INSTR_W = 16;

    // Instruction field positions
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [3:0] {
        OP_LDI  = 4'h0,
        OP_MOV  = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_OUT  = 4'h7,
        OP_JMP  = 4'h8,
        OP_JZ   = 4'h9,
        OP_JC   = 4'hA,
        OP_CALL = 4'hB,
        OP_RET  = 4'hC,
        OP_IN   = 4'hD,
        OP_NOP  = 4'hE,
        OP_HLT  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

endpackage

// File: rtl/borus_alu.sv
// Combinational ALU for the Borus v2 core. Carry is the carry-out for ADD and
// the unsigned borrow for SUB; logic ops clear it.
module borus_alu
    import borus_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  opcode_e             op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [DATA_W-1:0]   result,
    output logic                carry,
    output logic                zero
);

    // Operation select; non-ALU opcodes yield zero and are ignored by the core
    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
            OP_SUB:  {carry, result} = {1'b0, a} - {1'b0, b};
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: ;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/borus_cpu_core_v2.sv
// Borus v2 core: single-issue, one instruction per clock, 4-entry register
// file, Z/C flags, hardware call stack and RUN/HALT/FAULT control.
module borus_cpu_core_v2
    import borus_cpu_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    output logic [7:0]          instr_addr,
    input  logic [INSTR_W-1:0]  instr_data,
    input  logic [DATA_W-1:0]   in_port,
    output logic [DATA_W-1:0]   out_port,
    output logic                out_valid,
    input  logic                resume,
    output logic                halted,
    output logic                fault
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    // Index width for the stack array; the pointer itself needs one more
    // code to represent "full".
    localparam int AW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    state_e             state_q, state_d;
    logic [7:0]         pc_q, pc_d;
    logic [DATA_W-1:0]  regs_q [4];
    logic [DATA_W-1:0]  regs_d [4];
    logic               z_q, z_d;
    logic               c_q, c_d;
    logic [SP_W-1:0]    sp_q, sp_d;
    logic [DATA_W-1:0]  out_port_q, out_port_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         stack_q [STACK_DEPTH];
    logic               push_en;

    // Decoded instruction fields
    opcode_e            op;
    logic [1:0]         rd;
    logic [1:0]         rs;
    logic [7:0]         imm;
    logic [DATA_W-1:0]  imm_ext;
    logic [7:0]         pc_inc;
    logic               stack_full;
    logic               stack_empty;
    logic [AW-1:0]      push_idx;
    logic [AW-1:0]      pop_idx;

    logic [DATA_W-1:0]  alu_result;
    logic               alu_carry;
    logic               alu_zero;

    assign op          = opcode_e'(instr_data[OP_MSB:OP_LSB]);
    assign rd          = instr_data[RD_MSB:RD_LSB];
    assign rs          = instr_data[RS_MSB:RS_LSB];
    assign imm         = instr_data[IMM_MSB:IMM_LSB];
    assign imm_ext     = DATA_W'(imm);
    assign pc_inc      = pc_q + 8'd1;
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
    assign push_idx    = AW'(sp_q);
    assign pop_idx     = AW'(sp_q - SP_W'(1));

    borus_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (op),
        .a      (regs_q[rd]),
        .b      (regs_q[rs]),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    // Next-state decode: execute one instruction in RUN, wait in HALT, stick in FAULT
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        regs_d      = regs_q;
        z_d         = z_q;
        c_d         = c_q;
        sp_d        = sp_q;
        out_port_d  = out_port_q;
        out_valid_d = 1'b0;
        push_en     = 1'b0;
        case (state_q)
            ST_RUN: begin
                pc_d = pc_inc;
                case (op)
                    OP_LDI: regs_d[rd] = imm_ext;
                    OP_MOV: regs_d[rd] = regs_q[rs];
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        regs_d[rd] = alu_result;
                        z_d        = alu_zero;
                        c_d        = alu_carry;
                    end
                    OP_OUT: begin
                        out_port_d  = regs_q[rd];
                        out_valid_d = 1'b1;
                    end
                    OP_JMP: pc_d = imm;
                    OP_JZ:  if (z_q) pc_d = imm;
                    OP_JC:  if (c_q) pc_d = imm;
                    OP_CALL: begin
                        if (stack_full) begin
                            state_d = ST_FAULT;
                            pc_d    = pc_q;
                        end else begin
                            push_en = 1'b1;
                            sp_d    = sp_q + SP_W'(1);
                            pc_d    = imm;
                        end
                    end
                    OP_RET: begin
                        if (stack_empty) begin
                            state_d = ST_FAULT;
                            pc_d    = pc_q;
                        end else begin
                            sp_d = sp_q - SP_W'(1);
                            pc_d = stack_q[pop_idx];
                        end
                    end
                    OP_IN:  regs_d[rd] = in_port;
                    OP_HLT: state_d = ST_HALT;
                    default: ;
                endcase
            end
            ST_HALT: begin
                if (resume) state_d = ST_RUN;
            end
            default: state_d = ST_FAULT;
        endcase
    end

    // Architectural state register; reset aborts any in-flight instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pc_q        <= '0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            sp_q        <= '0;
            out_port_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            regs_q      <= regs_d;
            z_q         <= z_d;
            c_q         <= c_d;
            sp_q        <= sp_d;
            out_port_q  <= out_port_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Return-address storage; contents are meaningless while sp is reset, so no reset here
    always_ff @(posedge clk) begin
        if (push_en) stack_q[push_idx] <= pc_inc;
    end

    assign instr_addr = pc_q;
    assign out_port   = out_port_q;
    assign out_valid  = out_valid_q;
    assign halted     = (state_q != ST_RUN);
    assign fault      = (state_q == ST_FAULT);

endmodule

// File: tb/tb_borus_cpu_core_v2.sv
// Directed bench for borus_cpu_core_v2: small ROM programs, OUT values are
// scoreboarded, control state (pc/halted/fault) is checked at known cycles.
module tb_borus_cpu_core_v2;
    import borus_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  instr_addr;
    logic [15:0] instr_data;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic        out_valid;
    logic        resume;
    logic        halted;
    logic        fault;

    logic [15:0] rom [256];
    logic [7:0]  exp_q [$];
    int          checks = 0;
    int          errors = 0;

    assign instr_data = rom[instr_addr];

    always #5 clk = ~clk;

    borus_cpu_core_v2 #(
        .DATA_W      (8),
        .STACK_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .in_port    (in_port),
        .out_port   (out_port),
        .out_valid  (out_valid),
        .resume     (resume),
        .halted     (halted),
        .fault      (fault)
    );

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // Scoreboard monitor: every out_valid cycle must match the next queued value
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst === 1'b0 && out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got %0h, expected no output", out_port);
            end else begin
                e = exp_q.pop_front();
                if (out_port !== e) begin
                    errors++;
                    $display("FAIL out_port: got %0h, expected %0h", out_port, e);
                end else begin
                    $display("ok   out_port = %0h", out_port);
                end
            end
        end
    end

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = enc(OP_NOP, 2'd0, 2'd0, 8'h00);
    endtask

    // Hold reset while the caller's program is already in the ROM
    task automatic reset_dut();
        rst    = 1'b1;
        resume = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_until_halt(input string name, input int max_cycles);
        bit done = 1'b0;
        for (int k = 0; k < max_cycles && !done; k++) begin
            step(1);
            done = halted;
        end
        chk({name, "_halted"}, 32'(halted), 32'd1);
    endtask

    task automatic drain_check(input string name);
        step(2);
        chk({name, "_pending_outs"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resume  = 1'b0;
        in_port = 8'h00;

        // Test 1: ADD with carry, JC taken, MOV
        clear_rom();
        rom[8'h00] = enc(OP_LDI, 2'd0, 2'd0, 8'd200);
        rom[8'h01] = enc(OP_LDI, 2'd1, 2'd0, 8'd100);
        rom[8'h02] = enc(OP_ADD, 2'd0, 2'd1, 8'h00);
        rom[8'h03] = enc(OP_JC,  2'd0, 2'd0, 8'h20);
        rom[8'h04] = enc(OP_HLT, 2'd0, 2'd0, 8'h00);
        rom[8'h20] = enc(OP_OUT, 2'd0, 2'd0, 8'h00);
        rom[8'h21] = enc(OP_MOV, 2'd3, 2'd1, 8'h00);
        rom[8'h22] = enc(OP_OUT, 2'd3, 2'd0, 8'h00);
        rom[8'h23] = enc(OP_HLT, 2'd0, 2'd0, 8'h00);
        reset_dut();
        chk("rst_pc",        32'(instr_addr), 32'd0);
        chk("rst_out_port",  32'(out_port),   32'd0);
        chk("rst_out_valid", 32'(out_valid),  32'd0);
        chk("rst_halted",    32'(halted),     32'd0);
        chk("rst_fault",     32'(fault),      32'd0);
        exp_q.push_back(8'd44);
        exp_q.push_back(8'd100);
        run_until_halt("t1", 40);
        chk("t1_pc", 32'(instr_addr), 32'h24);
        chk("t1_fault", 32'(fault), 32'd0);
        drain_check("t1");

        // Test 2: SUB to zero + JZ, borrow + JC, logic ops clearing C
        clear_rom();
        rom[8'h00] = enc(OP_LDI, 2'd2, 2'd0, 8'd5);
        rom[8'h01] = enc(OP_LDI, 2'd3, 2'd0, 8'd5);
        rom[8'h02] = enc(OP_SUB, 2'd2, 2'd3, 8'h00);
        rom[8'h03] = enc(OP_JZ,  2'd0, 2'd0, 8'h10);
        rom[8'h04] = enc(OP_HLT, 2'd0, 2'd0, 8'h00);
        rom[8'h10] = enc(OP_OUT, 2'd2, 2'd0, 8'h00);
        rom[8'h11] = enc(OP_LDI, 2'd0, 2'd0, 8'd3);
        rom[8'h12] = enc(OP_LDI, 2'd1, 2'd0, 8'd5);
        rom[8'h13] = enc(OP_SUB, 2'd0, 2'd1, 8'h00);
        rom[8'h14] = enc(OP_JC,  2'd0, 2'd0, 8'h18);
        rom[8'h15] = enc(OP_HLT, 2'd0, 2'd0, 8'h00);
        rom[8'h18] = enc(OP_OUT, 2'd0, 2'd0, 8'h00);
        rom[8'h19] = enc(OP_AND, 2'd0, 2'd0, 8'h00);
        rom[8'h1A] = enc(OP_JC,  2'd0, 2'd0, 8'h30);
        rom[8'h1B] = enc(OP_JZ,  2'd0, 2'd0, 8'h30);
        rom[8'h1C] = enc(OP_XOR, 2'd0, 2'd0, 8'h00);
        rom[8'h1D] = enc(OP_OUT, 2'd0, 2'd0, 8'h00);
        rom[8'h1E] = enc(OP_HLT, 2'd0, 2'd0, 8'h00);
        rom[8'h30] = enc(OP_HLT, 2'd0, 2'd0, 8'h00);
        reset_dut();
        exp_q.push_back(8'd0);
        exp_q.push_back(8'd254);
        exp_q.push_back(8'd0);
        run_until_halt("t2", 60);
        chk("t2_pc", 32'(instr_addr), 32'h1F);
        drain_check("t2");

        // Test 3a: CALL / RET return address
        clear_rom();
        rom[8'h00] = enc(OP_CALL, 2'd0, 2'd0, 8'h40);
        rom[8'h01] = enc(OP_HLT,  2'd0, 2'd0, 8'h00);
        rom[8'h40] = enc(OP_OUT,  2'd0, 2'd0, 8'h00);
        rom[8'h41] = enc(OP_RET,  2'd0, 2'd0, 8'h00);
        reset_dut();
        exp_q.push_back(8'd0);
        step(1);
        chk("t3_call_pc", 32'(instr_addr), 32'h40);
        step(2);
        chk("t3_ret_pc", 32'(instr_addr), 32'h01);
        run_until_halt("t3", 10);
        chk("t3_pc", 32'(instr_addr), 32'h02);
        drain_check("t3");

        // Test 3b: nested returns pop in LIFO order
        clear_rom();
        rom[8'h00] = enc(OP_CALL, 2'd0, 2'd0, 8'h10);
        rom[8'h01] = enc(OP_HLT,  2'd0, 2'd0, 8'h00);
        rom[8'h10] = enc(OP_CALL, 2'd0, 2'd0, 8'h20);
        rom[8'h11] = enc(OP_RET,  2'd0, 2'd0, 8'h00);
        rom[8'h20] = enc(OP_RET,  2'd0, 2'd0, 8'h00);
        reset_dut();
        step(3);
        chk("t3b_inner_ret_pc", 32'(instr_addr), 32'h11);
        step(1);
        chk("t3b_outer_ret_pc", 32'(instr_addr), 32'h01);
        chk("t3b_fault", 32'(fault), 32'd0);

        // Test 3c: fifth nested CALL overflows the 4-deep stack
        clear_rom();
        for (int i = 0; i < 5; i++) rom[i] = enc(OP_CALL, 2'd0, 2'd0, 8'(i + 1));
        reset_dut();
        step(4);
        chk("t3c_depth4_pc", 32'(instr_addr), 32'h04);
        chk("t3c_depth4_fault", 32'(fault), 32'd0);
        step(1);
        chk("t3c_ovf_fault", 32'(fault), 32'd1);
        chk("t3c_ovf_halted", 32'(halted), 32'd1);
        chk("t3c_ovf_pc", 32'(instr_addr), 32'h04);

        // Test 4: RET on empty stack faults; resume cannot leave FAULT
        clear_rom();
        rom[8'h00] = enc(OP_RET, 2'd0, 2'd0, 8'h00);
        reset_dut();
        step(1);
        chk("t4_fault", 32'(fault), 32'd1);
        chk("t4_halted", 32'(halted), 32'd1);
        chk("t4_pc", 32'(instr_addr), 32'h00);
        resume = 1'b1;
        step(3);
        resume = 1'b0;
        step(1);
        chk("t4_resume_fault", 32'(fault), 32'd1);
        chk("t4_resume_pc", 32'(instr_addr), 32'h00);

        // Test 5: HLT at pc 3, same-cycle resume ignored, later resume continues at 4
        clear_rom();
        rom[8'h00] = enc(OP_LDI, 2'd0, 2'd0, 8'd7);
        rom[8'h01] = enc(OP_LDI, 2'd1, 2'd0, 8'd9);
        rom[8'h02] = enc(OP_NOP, 2'd0, 2'd0, 8'h00);
        rom[8'h03] = enc(OP_HLT, 2'd0, 2'd0, 8'h00);
        rom[8'h04] = enc(OP_OUT, 2'd0, 2'd0, 8'h00);
        rom[8'h05] = enc(OP_HLT, 2'd0, 2'd0, 8'h00);
        reset_dut();
        chk("t5_rst_fault_cleared", 32'(fault), 32'd0);
        step(3);
        chk("t5_pre_hlt_pc", 32'(instr_addr), 32'h03);
        resume = 1'b1;
        step(1);
        resume = 1'b0;
        chk("t5_hlt_halted", 32'(halted), 32'd1);
        chk("t5_hlt_pc", 32'(instr_addr), 32'h04);
        step(10);
        chk("t5_hold_halted", 32'(halted), 32'd1);
        chk("t5_hold_pc", 32'(instr_addr), 32'h04);
        resume = 1'b1;
        step(1);
        resume = 1'b0;
        chk("t5_resume_halted", 32'(halted), 32'd0);
        chk("t5_resume_pc", 32'(instr_addr), 32'h04);
        exp_q.push_back(8'd7);
        step(1);
        chk("t5_exec_pc", 32'(instr_addr), 32'h05);
        run_until_halt("t5", 5);
        chk("t5_pc", 32'(instr_addr), 32'h06);
        drain_check("t5");

        // Test 6: asynchronous reset while IN is pending aborts it
        clear_rom();
        rom[8'h00] = enc(OP_OUT, 2'd0, 2'd0, 8'h00);
        rom[8'h01] = enc(OP_LDI, 2'd0, 2'd0, 8'h11);
        rom[8'h02] = enc(OP_OUT, 2'd0, 2'd0, 8'h00);
        rom[8'h03] = enc(OP_IN,  2'd0, 2'd0, 8'h00);
        rom[8'h04] = enc(OP_OUT, 2'd0, 2'd0, 8'h00);
        rom[8'h05] = enc(OP_HLT, 2'd0, 2'd0, 8'h00);
        in_port = 8'hA5;
        reset_dut();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h11);
        step(3);
        chk("t6_pre_rst_pc", 32'(instr_addr), 32'h03);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_arst_pc",        32'(instr_addr), 32'd0);
        chk("t6_arst_out_port",  32'(out_port),   32'd0);
        chk("t6_arst_out_valid", 32'(out_valid),  32'd0);
        chk("t6_arst_halted",    32'(halted),     32'd0);
        chk("t6_arst_fault",     32'(fault),      32'd0);
        chk("t6_pre_rst_outs_seen", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'hA5);
        run_until_halt("t6", 20);
        chk("t6_pc", 32'(instr_addr), 32'h06);
        drain_check("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
